// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI transmit arbiter slice.
//   SPI_NREQ : number of requesters sharing the SPI master
//   SPI_DW   : frame width, matches the SPI master din width
//   SPI_TMO  : default launch timeout in clk cycles
//   state_t  : arbiter FSM state encoding
package spi_pkg;

    localparam int unsigned SPI_NREQ = 4;
    localparam int unsigned SPI_DW   = 12;
    localparam int unsigned SPI_TMO  = 1023;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// Bundle between the requesters / SPI master and the arbiter.
//   req, req_data : level requests and per-requester frames (requester i at [i*DW +: DW])
//   spi_cs        : chip select returned by the SPI master (low = frame in flight)
//   gnt           : one-hot capture pulse back to the requesters
//   newd, din     : new-data strobe and frame towards the SPI master
//   busy, done, err, owner : link status
// slave  : seen by the arbiter
// master : seen by whoever drives requests and models the SPI master
interface spi_tx_arbiter_if #(
    parameter int unsigned NREQ = spi_pkg::SPI_NREQ,
    parameter int unsigned DW   = spi_pkg::SPI_DW
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               spi_cs;
    logic [NREQ-1:0]    gnt;
    logic               newd;
    logic [DW-1:0]      din;
    logic               busy;
    logic               done;
    logic               err;
    logic [IW-1:0]      owner;

    modport slave (
        input  req, req_data, spi_cs,
        output gnt, newd, din, busy, done, err, owner
    );

    modport master (
        output req, req_data, spi_cs,
        input  gnt, newd, din, busy, done, err, owner
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches from last+1 upward (wrapping)
// and returns the first requester whose req bit is set.
//   req     : request vector
//   last    : index of the requester served most recently
//   valid_c : at least one request is present
//   idx_c   : winning requester index (meaningful only when valid_c)
module rr_arbiter #(
    parameter int unsigned NREQ = spi_pkg::SPI_NREQ,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid_c,
    output logic [IW-1:0]   idx_c
);

    logic [IW-1:0] cand_c;

    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        cand_c  = '0;
        for (int unsigned off = NREQ; off > 0; off--) begin
            cand_c = IW'((32'(last) + off) % NREQ);
            if (req[cand_c]) begin
                idx_c = cand_c;
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Arbitrates NREQ requesters onto a single SPI master. A winning frame is
// captured into din, newd is held until the master drops spi_cs, and the
// link is released when spi_cs returns high (done) or the launch times out (err).
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : spi_tx_arbiter_if slave modport (requests, SPI handshake, status)
module spi_tx_arbiter #(
    parameter int unsigned NREQ = spi_pkg::SPI_NREQ,
    parameter int unsigned DW   = spi_pkg::SPI_DW,
    parameter int unsigned TMO  = spi_pkg::SPI_TMO
) (
    input  logic                clk,
    input  logic                rst,
    spi_tx_arbiter_if.slave     bus
);
    import spi_pkg::*;

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [DW-1:0]   din_q, din_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            newd_q, newd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            pick_valid_c;
    logic [IW-1:0]   pick_idx_c;
    logic            tmo_hit_c;
    logic [DW-1:0]   req_frame [NREQ];

    // Split the flat request data into per-requester frames.
    for (genvar g = 0; g < NREQ; g++) begin : g_frame
        assign req_frame[g] = bus.req_data[g*DW +: DW];
    end

    assign tmo_hit_c = (cnt_q == CW'(TMO));

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req     (bus.req),
        .last    (last_q),
        .valid_c (pick_valid_c),
        .idx_c   (pick_idx_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!bus.spi_cs) begin
                    state_d = ST_WAIT_END;
                end else if (tmo_hit_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_END: begin
                if (bus.spi_cs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        gnt_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        newd_d  = newd_q;
        din_d   = din_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    gnt_d   = NREQ'(1) << pick_idx_c;
                    din_d   = req_frame[pick_idx_c];
                    owner_d = pick_idx_c;
                    newd_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_LAUNCH: begin
                if (!bus.spi_cs) begin
                    newd_d = 1'b0;
                end else if (tmo_hit_c) begin
                    newd_d = 1'b0;
                    err_d  = 1'b1;
                    last_d = owner_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_END: begin
                if (bus.spi_cs) begin
                    done_d = 1'b1;
                    last_d = owner_q;
                end
            end
            default: begin
                newd_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Output and datapath registers; last_q resets so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            newd_q  <= 1'b0;
            busy_q  <= 1'b0;
            din_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            newd_q  <= newd_d;
            busy_q  <= busy_d;
            din_q   <= din_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.newd  = newd_q;
    assign bus.din   = din_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter: a behavioural SPI master serializes each
// launched frame LSB-first on mosi; grants are predicted from the
// round-robin rule applied to the current request vector.
module tb_spi_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 12;
    localparam int unsigned TMO  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int end_cyc = 0;
    int mlast   = 3;
    bit spi_en  = 1'b1;
    int cs_delay = 0;
    logic mosi;
    logic [DW-1:0] frames [$];
    logic [DW-1:0] fr [4];
    logic [DW-1:0] m_sr, m_rx;
    bit m_abort;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPI master: on newd, optionally wait, drop cs, shift DW bits, raise cs.
    initial begin
        bus.spi_cs = 1'b1;
        mosi = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_en && bus.newd && !rst) begin
                m_sr = bus.din;
                m_rx = '0;
                m_abort = 1'b0;
                repeat (cs_delay) @(negedge clk);
                #1 bus.spi_cs = 1'b0;
                for (int b = 0; b < DW && !m_abort; b++) begin
                    @(negedge clk);
                    #1;
                    if (rst) begin
                        m_abort = 1'b1;
                    end else begin
                        mosi = m_sr[0];
                        m_rx = {mosi, m_rx[DW-1:1]};
                        m_sr = m_sr >> 1;
                    end
                end
                bus.spi_cs = 1'b1;
                if (!m_abort) frames.push_back(m_rx);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    // Round-robin reference: first set request after 'last', wrapping.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        int p = -1;
        for (int k = 1; k <= 4; k++) begin
            if (p < 0 && ((r >> ((last + k) % 4)) & 4'd1) != 4'd0) p = (last + k) % 4;
        end
        return p;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    task automatic rand_frames();
        for (int i = 0; i < 4; i++) fr[i] = 12'($urandom);
    endtask

    task automatic apply_req(input logic [3:0] r);
        bus.req = r;
        bus.req_data = {fr[3], fr[2], fr[1], fr[0]};
    endtask

    task automatic do_reset();
        apply_req(4'b0000);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mlast = 3;
        frames.delete();
        end_cyc = cyc;
    endtask

    task automatic wait_grant(output bit ok, output logic [3:0] g, output logic [1:0] own,
                              output logic [DW-1:0] d, output int gap);
        ok = 1'b0; g = '0; own = '0; d = '0; gap = -1;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                ok = 1'b1; g = bus.gnt; own = bus.owner; d = bus.din; gap = cyc - end_cyc;
            end
        end
    endtask

    // st: 0 done, 1 err, 2 no end seen, 3 grant while frame active
    task automatic wait_end(output int st, output logic [DW-1:0] frm);
        st = -1;
        frm = 'x;
        for (int t = 0; t < 100 && st < 0; t++) begin
            @(negedge clk);
            if (bus.gnt != '0) st = 3;
            else if (bus.done) st = 0;
            else if (bus.err) st = 1;
        end
        if (st < 0) st = 2;
        end_cyc = cyc;
        if (frames.size() > 0) frm = frames.pop_front();
    endtask

    task automatic test_reset();
        int ng;
        rand_frames();
        apply_req(4'b0000);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.newd !== 1'b0) begin errors++; $display("FAIL reset_newd: got %b expected 0", bus.newd); end
        checks++; if (bus.din !== 12'h000) begin errors++; $display("FAIL reset_din: got %h expected 000", bus.din); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
        rst = 1'b0;
        mlast = 3;
        ng = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.gnt != '0 || bus.busy) ng++;
        end
        checks++; if (ng != 0) begin errors++; $display("FAIL reset_idle_no_req: got %0d active cycles expected 0", ng); end
    endtask

    task automatic test_single();
        bit ok; logic [3:0] g; logic [1:0] own; logic [DW-1:0] d, frm; int gap, st, c0, nh;
        rand_frames();
        fr[2] = 12'hA5C;
        cs_delay = 3;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mlast = 3;
        frames.delete();
        apply_req(4'b0100);
        c0 = cyc;
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", g); end
        checks++; if (cyc - c0 != 1) begin errors++; $display("FAIL single_first_cycle: got latency %0d expected 1", cyc - c0); end
        checks++; if (own !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected 2", own); end
        checks++; if (d !== 12'hA5C) begin errors++; $display("FAIL single_din: got %h expected a5c", d); end
        checks++; if (bus.newd !== 1'b1) begin errors++; $display("FAIL single_newd_at_gnt: got %b expected 1", bus.newd); end
        apply_req(4'b0000);
        nh = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.newd && bus.gnt == '0) nh++;
        end
        checks++; if (nh != 3) begin errors++; $display("FAIL single_newd_hold: got %0d cycles expected 3", nh); end
        @(negedge clk);
        checks++; if (bus.newd !== 1'b0) begin errors++; $display("FAIL single_newd_drop: got %b expected 0", bus.newd); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.din !== 12'hA5C) begin errors++; $display("FAIL single_din_hold: got %h expected a5c", bus.din); end
        wait_end(st, frm);
        checks++; if (st != 0) begin errors++; $display("FAIL single_done: got status %0d expected 0", st); end
        checks++; if (frm !== 12'hA5C) begin errors++; $display("FAIL single_mosi: got %h expected a5c", frm); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus.busy); end
        mlast = 2;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", bus.done); end
        cs_delay = 0;
    endtask

    task automatic test_all_four();
        bit ok; logic [3:0] g; logic [1:0] own; logic [DW-1:0] d, frm; int gap, st;
        int ord [5] = '{0, 1, 2, 3, 0};
        do_reset();
        rand_frames();
        apply_req(4'b1111);
        for (int n = 0; n < 5; n++) begin
            wait_grant(ok, g, own, d, gap);
            checks++; if (!ok || g !== onehot(ord[n])) begin errors++; $display("FAIL all4_gnt[%0d]: got %b expected %b", n, g, onehot(ord[n])); end
            checks++; if (d !== fr[ord[n]]) begin errors++; $display("FAIL all4_din[%0d]: got %h expected %h", n, d, fr[ord[n]]); end
            if (n > 0) begin
                checks++; if (gap != 1) begin errors++; $display("FAIL all4_gap[%0d]: got %0d expected 1", n, gap); end
            end
            wait_end(st, frm);
            checks++; if (st != 0) begin errors++; $display("FAIL all4_end[%0d]: got status %0d expected 0", n, st); end
            checks++; if (frm !== fr[ord[n]]) begin errors++; $display("FAIL all4_mosi[%0d]: got %h expected %h", n, frm, fr[ord[n]]); end
            mlast = ord[n];
        end
        apply_req(4'b0000);
    endtask

    task automatic test_fairness();
        bit ok; logic [3:0] g; logic [1:0] own; logic [DW-1:0] d, frm; int gap, st, exp, prev;
        do_reset();
        rand_frames();
        apply_req(4'b0101);
        prev = -1;
        for (int n = 0; n < 4; n++) begin
            exp = rr_pick(4'b0101, mlast);
            wait_grant(ok, g, own, d, gap);
            checks++; if (!ok || g !== onehot(exp)) begin errors++; $display("FAIL fair_gnt[%0d]: got %b expected %b", n, g, onehot(exp)); end
            checks++; if (int'(own) == prev) begin errors++; $display("FAIL fair_double[%0d]: got owner %0d expected not %0d", n, own, prev); end
            wait_end(st, frm);
            checks++; if (st != 0 || frm !== fr[exp]) begin errors++; $display("FAIL fair_frame[%0d]: got status %0d data %h expected 0 %h", n, st, frm, fr[exp]); end
            prev = int'(own);
            mlast = exp;
        end
        apply_req(4'b0010);
        for (int n = 0; n < 3; n++) begin
            wait_grant(ok, g, own, d, gap);
            checks++; if (!ok || g !== 4'b0010) begin errors++; $display("FAIL solo_gnt[%0d]: got %b expected 0010", n, g); end
            checks++; if (gap != 1) begin errors++; $display("FAIL solo_gap[%0d]: got %0d expected 1", n, gap); end
            wait_end(st, frm);
            checks++; if (st != 0 || frm !== fr[1]) begin errors++; $display("FAIL solo_frame[%0d]: got status %0d data %h expected 0 %h", n, st, frm, fr[1]); end
            mlast = 1;
        end
        apply_req(4'b0000);
    endtask

    task automatic test_timeout();
        bit ok; logic [3:0] g, r; logic [1:0] own; logic [DW-1:0] d, frm;
        int gap, st, exp, errat, nh, dn;
        logic errnewd, errbusy;
        spi_en = 1'b0;
        rand_frames();
        r = 4'($urandom_range(1, 15));
        exp = rr_pick(r, mlast);
        apply_req(r);
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== onehot(exp)) begin errors++; $display("FAIL tmo_gnt: got %b expected %b", g, onehot(exp)); end
        apply_req(4'b0000);
        errat = -1; nh = 0; dn = 0; errnewd = 1'bx; errbusy = 1'bx;
        for (int i = 1; i <= 40 && errat < 0; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.err) begin
                errat = i; errnewd = bus.newd; errbusy = bus.busy;
            end else if (bus.newd) begin
                nh++;
            end
        end
        checks++; if (errat != 16) begin errors++; $display("FAIL tmo_err_time: got %0d expected 16", errat); end
        checks++; if (nh != 15) begin errors++; $display("FAIL tmo_newd_hold: got %0d expected 15", nh); end
        checks++; if (errnewd !== 1'b0) begin errors++; $display("FAIL tmo_newd_drop: got %b expected 0", errnewd); end
        checks++; if (errbusy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", errbusy); end
        checks++; if (dn != 0) begin errors++; $display("FAIL tmo_no_done: got %0d expected 0", dn); end
        mlast = exp;
        end_cyc = cyc;
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse: got %b expected 0", bus.err); end
        spi_en = 1'b1;
        rand_frames();
        r = 4'($urandom_range(1, 15));
        exp = rr_pick(r, mlast);
        apply_req(r);
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== onehot(exp)) begin errors++; $display("FAIL tmo_next_gnt: got %b expected %b", g, onehot(exp)); end
        apply_req(4'b0000);
        wait_end(st, frm);
        checks++; if (st != 0 || frm !== fr[exp]) begin errors++; $display("FAIL tmo_next_frame: got status %0d data %h expected 0 %h", st, frm, fr[exp]); end
        mlast = exp;
    endtask

    task automatic test_reset_mid();
        bit ok; logic [3:0] g, r; logic [1:0] own; logic [DW-1:0] d, frm; int gap, st, exp, act;
        cs_delay = 0;
        rand_frames();
        r = 4'($urandom_range(1, 7)) << 1;
        exp = rr_pick(r, mlast);
        apply_req(r);
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== onehot(exp)) begin errors++; $display("FAIL rmid_gnt: got %b expected %b", g, onehot(exp)); end
        apply_req(4'b0000);
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b1 || bus.spi_cs !== 1'b0) begin errors++; $display("FAIL rmid_in_frame: got busy %b cs %b expected 1 0", bus.busy, bus.spi_cs); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.newd !== 1'b0) begin errors++; $display("FAIL rmid_newd: got %b expected 0", bus.newd); end
        checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rmid_no_end: got done %b err %b expected 0 0", bus.done, bus.err); end
        rst = 1'b0;
        mlast = 3;
        frames.delete();
        act = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.gnt != '0) act++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL rmid_quiet: got %0d events expected 0", act); end
        apply_req(4'b1111);
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL rmid_next_gnt: got %b expected 0001", g); end
        apply_req(4'b0000);
        wait_end(st, frm);
        checks++; if (st != 0 || frm !== fr[0]) begin errors++; $display("FAIL rmid_next_frame: got status %0d data %h expected 0 %h", st, frm, fr[0]); end
        mlast = 0;
    endtask

    task automatic test_busy_change();
        bit ok; logic [3:0] g; logic [1:0] own; logic [DW-1:0] d, frm; int gap, st;
        rand_frames();
        apply_req(4'b0001);
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL chg_first_gnt: got %b expected 0001", g); end
        apply_req(4'b1000);
        wait_end(st, frm);
        checks++; if (st != 0) begin errors++; $display("FAIL chg_no_gnt_busy: got status %0d expected 0", st); end
        checks++; if (frm !== fr[0]) begin errors++; $display("FAIL chg_frame: got %h expected %h", frm, fr[0]); end
        mlast = 0;
        wait_grant(ok, g, own, d, gap);
        checks++; if (!ok || g !== 4'b1000) begin errors++; $display("FAIL chg_second_gnt: got %b expected 1000", g); end
        checks++; if (gap != 1) begin errors++; $display("FAIL chg_gap: got %0d expected 1", gap); end
        apply_req(4'b0000);
        wait_end(st, frm);
        checks++; if (st != 0 || frm !== fr[3]) begin errors++; $display("FAIL chg_second_frame: got status %0d data %h expected 0 %h", st, frm, fr[3]); end
        mlast = 3;
    endtask

    task automatic test_random();
        bit ok; logic [3:0] g; logic [1:0] own; logic [DW-1:0] d, frm, expd; int gap, st, exp;
        rand_frames();
        apply_req(4'($urandom_range(1, 15)));
        for (int n = 0; n < 30; n++) begin
            exp = rr_pick(bus.req, mlast);
            expd = fr[exp];
            cs_delay = int'($urandom_range(0, 4));
            wait_grant(ok, g, own, d, gap);
            checks++; if (!ok || g !== onehot(exp)) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", n, g, onehot(exp)); end
            checks++; if (own !== 2'(exp) || d !== expd) begin errors++; $display("FAIL rnd_capture[%0d]: got owner %0d din %h expected %0d %h", n, own, d, exp, expd); end
            rand_frames();
            apply_req(4'($urandom_range(1, 15)));
            wait_end(st, frm);
            checks++; if (st != 0 || frm !== expd) begin errors++; $display("FAIL rnd_frame[%0d]: got status %0d data %h expected 0 %h", n, st, frm, expd); end
            mlast = exp;
        end
        apply_req(4'b0000);
        cs_delay = 0;
    endtask

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_busy_change();
        test_random();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4 in this release.
REQ-002 Parameter DW, default 12, frame width; matches the SPI master din width.
REQ-003 Parameter TMO, default 1023, clk cycles allowed for cs to fall after launch.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester level request; held until granted.
REQ-007 req_data  input  NREQ*DW  requester i frame at bits [i*DW +: DW].
REQ-008 spi_cs  input  1  chip select returned from the SPI master; low means frame in flight.
REQ-009 gnt  output  NREQ  one-hot, one-cycle pulse; requester i's frame was captured.
REQ-010 newd  output  1  new-data strobe to the SPI master.
REQ-011 din  output  DW  frame to the SPI master.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the launched frame completes (spi_cs returns high).
REQ-014 err  output  1  one-cycle pulse on launch timeout.
REQ-015 owner  output  2  index of the requester that currently owns the link; valid while busy.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT_END.
REQ-017 IDLE: with any req bit high, the block selects the winner, captures its data into din, pulses gnt[winner], sets owner, and goes to LAUNCH on the same edge.
REQ-018 Arbitration is round-robin: search starts at last_served+1 mod NREQ and wraps; the first set req bit wins.
REQ-019 LAUNCH: newd is held high (the master samples it only on slow sclk edges), din is held stable, and a timeout counter increments from 0.
REQ-020 LAUNCH -> WAIT_END on the first cycle spi_cs is sampled low; newd deasserts on that edge.
REQ-021 LAUNCH -> IDLE when the counter reaches TMO with spi_cs still high: newd drops, err pulses, and last_served updates to owner.
REQ-022 WAIT_END -> IDLE on the first cycle spi_cs is sampled high: done pulses and last_served updates to owner.
REQ-023 din holds its value from capture until the next grant; it is never altered while busy.
REQ-024 req changes while busy are ignored; no grant issues while busy.
REQ-025 Minimum spacing is one IDLE cycle between done/err and the next gnt.
REQ-026 A gnt, done and err pulse never occur in the same cycle.
REQ-027 With a single requester asserting continuously, that requester is re-granted every frame.

Reset
REQ-028 On rst: state=IDLE, gnt=0, newd=0, din=0, busy=0, done=0, err=0, owner=0, timeout counter=0, last_served=NREQ-1 (requester 0 has first priority).
REQ-029 rst mid-frame aborts immediately; no done or err pulse is issued for the aborted frame.
REQ-030 On the first cycle after reset, the block grants only if req is high in that cycle.

Structure
REQ-031 Shared package spi_pkg holds the state enum typedef and the DW and NREQ defaults.
REQ-032 One sub-module, rr_arbiter (combinational round-robin pick from req and last_served), is natural; the FSM, counter and registers live in the top.

Verification
REQ-033 Single request: req=4'b0100 with data 12'hA5C -> gnt=4'b0100 for one cycle; newd held until cs falls; din=12'hA5C; done after cs rises; owner=2.
REQ-034 All four requesting continuously after reset -> grant order 0,1,2,3,0; each frame is serialized LSB-first on mosi matching its req_data.
REQ-035 Fairness: req0 and req2 always high -> grants alternate 0,2,0,2, with no double grant.
REQ-036 Timeout: spi_cs tied high, TMO=15 -> err pulses 16 cycles after gnt; newd drops; the next request is granted.
REQ-037 Reset mid-frame: assert rst during WAIT_END -> next cycle busy=0, newd=0, no done; the next grant goes to requester 0.
REQ-038 Request change while busy: req switches from 4'b0001 to 4'b1000 during a frame -> no gnt until done; then gnt=4'b1000.
